// File: rtl/bcd_2of5_serial_tx.sv
// Serial POSTNET-style frame sender: latches NDIG BCD digits on start and shifts out
// start bar, 2-of-5 coded digits (MSD first), coded mod-10 check digit and end bar.
module bcd_2of5_serial_tx #(
    parameter int unsigned NDIG       = 5,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] digits,
    output logic              ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic              err
);

    localparam int unsigned DW    = 4 * NDIG;
    localparam int unsigned DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned SUM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BAR,
        S_DIGITS,
        S_CHECK,
        S_END_BAR
    } state_t;

    function automatic logic [4:0] enc_2of5(input logic [3:0] d);
        logic [4:0] c;
        case (d)
            4'd0:    c = 5'b11000;
            4'd1:    c = 5'b00011;
            4'd2:    c = 5'b00101;
            4'd3:    c = 5'b00110;
            4'd4:    c = 5'b01001;
            4'd5:    c = 5'b01010;
            4'd6:    c = 5'b01100;
            4'd7:    c = 5'b10001;
            4'd8:    c = 5'b10010;
            4'd9:    c = 5'b10100;
            default: c = 5'b00000;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [2:0]         bit_q, bit_d;
    logic [DW-1:0]      data_q, data_d;
    logic [3:0]         chk_q, chk_d;
    logic               ready_q, ready_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_bad;
    logic [SUM_W-1:0]   in_sum;
    logic [SUM_W-1:0]   in_rem;
    logic [3:0]         in_chk;
    logic [3:0]         cur_digit;
    logic [4:0]         cur_code;

    // Validate incoming digits and precompute the check digit at accept time
    always_comb begin
        in_bad = 1'b0;
        in_sum = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (digits[4*i +: 4] > 4'd9) in_bad = 1'b1;
            in_sum = in_sum + SUM_W'(digits[4*i +: 4]);
        end
        in_rem = in_sum % SUM_W'(10);
        in_chk = (in_rem == '0) ? 4'd0 : 4'(SUM_W'(10) - in_rem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            dig_q       <= '0;
            bit_q       <= 3'd4;
            data_q      <= '0;
            chk_q       <= '0;
            ready_q     <= 1'b1;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            dig_q       <= dig_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            ready_q     <= ready_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state: cyc counts the hold time of the current bit, then the bit pointer advances
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        dig_d   = dig_q;
        bit_d   = bit_q;
        data_d  = data_q;
        chk_d   = chk_q;
        if (state_q == S_IDLE) begin
            if (start && !in_bad) begin
                state_d = S_START_BAR;
                cyc_d   = '0;
                dig_d   = '0;
                bit_d   = 3'd4;
                data_d  = digits;
                chk_d   = in_chk;
            end
        end else if (cyc_q != CYC_W'(BIT_CYCLES - 1)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end else begin
            cyc_d = '0;
            case (state_q)
                S_START_BAR: begin
                    state_d = S_DIGITS;
                    dig_d   = '0;
                    bit_d   = 3'd4;
                end
                S_DIGITS: begin
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                    end else if (dig_q == DIG_W'(NDIG - 1)) begin
                        state_d = S_CHECK;
                        bit_d   = 3'd4;
                    end else begin
                        dig_d = dig_q + DIG_W'(1);
                        bit_d = 3'd4;
                    end
                end
                S_CHECK: begin
                    if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
                    else               state_d = S_END_BAR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state view so they align with the state they describe
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (dig_d == DIG_W'(i)) cur_digit = data_d[4*(int'(NDIG)-1-i) +: 4];
        end
        cur_code    = (state_d == S_CHECK) ? enc_2of5(chk_d) : enc_2of5(cur_digit);
        ready_d     = (state_d == S_IDLE);
        ser_valid_d = (state_d != S_IDLE);
        ser_out_d   = 1'b0;
        case (state_d)
            S_START_BAR, S_END_BAR: ser_out_d = 1'b1;
            S_DIGITS, S_CHECK:      ser_out_d = cur_code[bit_d];
            default:                ser_out_d = 1'b0;
        endcase
        done_d = (state_q == S_END_BAR) && (state_d == S_IDLE);
        err_d  = (state_q == S_IDLE) && start && in_bad;
    end

    assign ready     = ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_2of5_serial_tx.sv
// Directed bench for bcd_2of5_serial_tx: table of hand-coded frames plus
// hand-written sequences for bit stretching, mid-frame reset and back-to-back frames.
module tb_bcd_2of5_serial_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [19:0] digits1, digits3;
    logic        ready1, ser_out1, ser_valid1, done1, err1;
    logic        ready3, ser_out3, ser_valid3, done3, err3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_2of5_serial_tx #(.NDIG(5), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .digits(digits1),
        .ready(ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .done(done1), .err(err1)
    );

    bcd_2of5_serial_tx #(.NDIG(5), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .digits(digits3),
        .ready(ready3), .ser_out(ser_out3), .ser_valid(ser_valid3),
        .done(done3), .err(err3)
    );

    typedef struct {
        logic [19:0] d;
        logic        is_err;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Samples 32 frame cycles of dut1; caller is in the first frame cycle (after a negedge)
    task automatic capture1(input bit mut, output logic [31:0] f, output int vcnt,
                            output int rcnt, output int ecnt);
        f = '0; vcnt = 0; rcnt = 0; ecnt = 0;
        for (int k = 0; k < 32; k++) begin
            f[31-k] = ser_out1;
            vcnt += int'(ser_valid1);
            rcnt += int'(!ready1);
            ecnt += int'(err1);
            if (mut && k == 10) digits1 = 20'hA0000;
            if (mut && k == 25) digits1 = 20'h98765;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int i);
        logic [31:0] f;
        int vcnt, rcnt, ecnt, dcnt;
        digits1 = vecs[i].d;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        if (vecs[i].is_err) begin
            chk($sformatf("v%0d_err_cycle", i), 32'({err1, ready1, ser_valid1, done1}), 32'b1100);
            @(negedge clk);
            chk($sformatf("v%0d_err_pulse_end", i), 32'(err1), 32'd0);
            vcnt = 0; dcnt = 0; rcnt = 0;
            for (int k = 0; k < 6; k++) begin
                vcnt += int'(ser_valid1);
                dcnt += int'(done1);
                rcnt += int'(!ready1);
                @(negedge clk);
            end
            chk($sformatf("v%0d_err_quiet", i), 32'(vcnt + dcnt + rcnt), 32'd0);
        end else begin
            capture1(1'b0, f, vcnt, rcnt, ecnt);
            chk($sformatf("v%0d_frame", i), f, vecs[i].frame);
            chk($sformatf("v%0d_valid_cycles", i), 32'(vcnt), 32'd32);
            chk($sformatf("v%0d_busy_cycles", i), 32'(rcnt), 32'd32);
            chk($sformatf("v%0d_done_cycle", i),
                32'({done1, ready1, ser_valid1, ser_out1, err1}), 32'b11000);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse_end", i), 32'(done1), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] f;
        int vcnt, rcnt, ecnt, hold_bad, dcnt;

        vecs[0] = '{20'h12345, 1'b0, 32'b1_00011_00101_00110_01001_01010_01010_1};
        vecs[1] = '{20'h00000, 1'b0, 32'b1_11000_11000_11000_11000_11000_11000_1};
        vecs[2] = '{20'h99999, 1'b0, 32'b1_10100_10100_10100_10100_10100_01010_1};
        vecs[3] = '{20'h12A45, 1'b1, 32'b0};
        vecs[4] = '{20'h10000, 1'b0, 32'b1_00011_11000_11000_11000_11000_10100_1};
        vecs[5] = '{20'h70814, 1'b0, 32'b1_10001_11000_10010_00011_01001_11000_1};
        vecs[6] = '{20'h98765, 1'b0, 32'b1_10100_10010_10001_01100_01010_01010_1};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; digits1 = '0; digits3 = '0;
        repeat (2) @(negedge clk);
        chk("reset_state1", 32'({ready1, ser_out1, ser_valid1, done1, err1}), 32'b10000);
        chk("reset_state3", 32'({ready3, ser_out3, ser_valid3, done3, err3}), 32'b10000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Stretched bits: each frame bit held for 3 cycles
        digits3 = 20'h10000;
        start3  = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        f = '0; vcnt = 0; hold_bad = 0;
        for (int k = 0; k < 96; k++) begin
            if (k % 3 == 0) f[31 - k/3] = ser_out3;
            else if (ser_out3 !== f[31 - k/3]) hold_bad++;
            vcnt += int'(ser_valid3);
            @(negedge clk);
        end
        chk("bc3_frame", f, vecs[4].frame);
        chk("bc3_hold", 32'(hold_bad), 32'd0);
        chk("bc3_valid_cycles", 32'(vcnt), 32'd96);
        chk("bc3_done_cycle", 32'({done3, ready3, ser_valid3}), 32'b110);

        // Reset during frame cycle 12
        digits1 = 20'h12345;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_reset_busy", 32'({ready1, ser_valid1}), 32'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_state", 32'({ready1, ser_out1, ser_valid1, done1, err1}), 32'b10000);
        vcnt = 0; dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            vcnt += int'(ser_valid1);
            dcnt += int'(done1);
            @(negedge clk);
        end
        chk("post_reset_quiet", 32'(vcnt + dcnt), 32'd0);
        run_vec(0);

        // Start held high across frames, digits disturbed mid-frame
        digits1 = 20'h12345;
        start1  = 1'b1;
        @(negedge clk);
        capture1(1'b1, f, vcnt, rcnt, ecnt);
        chk("b2b_frame1", f, vecs[0].frame);
        chk("b2b_no_err_busy", 32'(ecnt), 32'd0);
        chk("b2b_idle_cycle", 32'({done1, ready1, ser_valid1, err1}), 32'b1100);
        @(negedge clk);
        start1 = 1'b0;
        capture1(1'b0, f, vcnt, rcnt, ecnt);
        chk("b2b_frame2", f, vecs[6].frame);
        chk("b2b_frame2_valid", 32'(vcnt), 32'd32);
        chk("b2b_done2", 32'({done1, ready1, ser_valid1}), 32'b110);
        @(negedge clk);

        // Reset together with start: start dropped
        rst = 1'b1; digits1 = 20'h12345; start1 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0;
        chk("rst_start_state", 32'({ready1, ser_valid1, err1, done1}), 32'b1000);
        @(negedge clk);
        chk("rst_start_dropped", 32'({ready1, ser_valid1, err1, done1}), 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_2of5_serial_tx.md
Name: bcd_2of5_serial_tx

Overview:
Frame sequencer that drives the BCD to 2-of-5 encoding datapath over a multi-digit word. It captures NDIG BCD digits on a start handshake, validates them and computes a mod-10 check digit. It then shifts out a POSTNET-style frame: a start bar, the coded digits MSD first, the coded check digit and an end bar. It sits between the digit source and the bar/line driver.

Parameters:
NDIG, 5, number of BCD digits per frame (1..16)
BIT_CYCLES, 1, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to send; sampled only while ready=1
digits  input  4*NDIG  BCD digits; digit 0 (MSD, sent first) is in [4*NDIG-1 -: 4]
ready  output  1  block idle, start will be accepted
ser_out  output  1  serial frame bit
ser_valid  output  1  ser_out carries a frame bit
done  output  1  one-cycle pulse: frame completed
err  output  1  one-cycle pulse: start rejected, some digit >9

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=1, ser_out=0, ser_valid=0, done=0, err=0. State is IDLE.
- All outputs are registered.
- 2-of-5 code, applied to every digit and the check digit, sent MSB first:
  - 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
  - 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
- Check digit C = (10 - (sum of all NDIG digits mod 10)) mod 10. Any adder width is fine if the result matches for NDIG=16 and all digits 9.
- Frame bit order: start bar 1, then 5*NDIG data bits, then 5 check bits, then end bar 1. FRAME_BITS = 5*NDIG+7.
- States: IDLE -> START_BAR -> DIGITS -> CHECK -> END_BAR -> IDLE.
- IDLE:
  - ready=1 and ser_valid=0.
  - If start=1 at edge t and every digit is <=9: digits are latched, state goes to START_BAR and ready=0 from t+1.
  - From cycle t+1, ser_valid=1 and ser_out=1.
  - If any digit is >9: nothing is latched and the block stays in IDLE. err=1 during cycle t+1 only, and ready stays 1.
- Bit pacing:
  - Each frame bit is held for exactly BIT_CYCLES cycles.
  - ser_valid stays continuously 1 for FRAME_BITS*BIT_CYCLES cycles with no gaps.
- DIGITS: the digit index runs 0..NDIG-1 and the bit index runs 4..0 within each digit. The index wraps at the digit boundary.
- CHECK: sends the 5 bits of code(C).
- END_BAR: sends one 1 bit.
- Frame completion:
  - The cycle after the last END_BAR cycle: ser_valid=0, ser_out=0, ready=1 and done=1, for exactly one cycle.
  - A start in that same cycle is accepted normally, so back-to-back frames are separated by exactly one idle cycle.
- While busy: start is ignored and digits may change freely. Neither affects the frame in flight, and err is never raised.
- ser_out is 0 whenever ser_valid=0.
- Reset mid-frame has priority over everything: the next edge returns all outputs to their reset values. There is no done pulse and no partial resume.
- Reset asserted together with start: reset wins and the start is dropped.
- The latched digits are held stable for the whole frame. The check digit may be precomputed at accept or accumulated serially, but must be valid before CHECK begins.

Test Plan:
1. NDIG=5, BIT_CYCLES=1, digits=0x12345, start for 1 cycle -> ready low for 32 cycles.
   - ser_out over 32 cycles = 1 00011 00101 00110 01001 01010 01010 1 (C=5).
   - done=1 on cycle 33 with ready=1.
2. digits=0x00000 -> all data groups 11000, check C=0 -> 11000. Also run 0x99999 -> sum 45, C=5 -> check code 01010.
3. digits=0x12A45 -> err=1 for exactly one cycle after start. ser_valid never rises, done=0, ready stays 1.
4. BIT_CYCLES=3, digits=0x10000 -> every bit lasts 3 cycles and ser_valid is high for 96 cycles. Sum 1 gives C=9, so the check code is 10100.
5. Reset at frame cycle 12 -> on the next edge ser_valid=0, ready=1, no done. A fresh start then sends a complete, correct frame.
6. Start held high across frames, with digits changed mid-frame -> first frame is unaffected by the changes. Second frame starts on the done cycle, with exactly one idle cycle between frames, and carries the digits present at that start.
